// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed hex 7-segment scanner with frame-synchronous shadow
// capture, leading-zero blanking, PWM brightness and anti-ghost guard.
module seg7_scan_ctrl #(
  parameter int DIGITS         = 8,
  parameter int SCAN_DIV       = 1024,
  parameter int PWM_BITS       = 4,
  parameter int GUARD          = 4,
  parameter int ACTIVE_LOW_AN  = 1,
  parameter int ACTIVE_LOW_SEG = 1
) (
  input  logic                        CLK,
  input  logic                        RST_N,
  input  logic [4*DIGITS-1:0]         data,
  input  logic [DIGITS-1:0]           dp,
  input  logic [DIGITS-1:0]           digit_en,
  input  logic                        blank_lz,
  input  logic [PWM_BITS-1:0]         brightness,
  output logic [DIGITS-1:0]           anodes,
  output logic [6:0]                  segments,
  output logic                        seg_dp,
  output logic [$clog2(DIGITS)-1:0]   digit_idx,
  output logic                        frame_tick
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(DIGITS);
  localparam bit AL_AN  = (ACTIVE_LOW_AN != 0);
  localparam bit AL_SEG = (ACTIVE_LOW_SEG != 0);

  logic [CW-1:0]         div_cnt;
  logic [4*DIGITS-1:0]   sh_data;
  logic [DIGITS-1:0]     sh_dp;
  logic [DIGITS-1:0]     sh_en;
  logic                  sh_blz;
  logic [PWM_BITS-1:0]   sh_bri;

  logic [DIGITS-1:0]     blank;
  logic                  chain;
  logic [3:0]            nib;
  logic [6:0]            dec;
  logic [PWM_BITS-1:0]   phase;
  logic                  lit;
  logic [DIGITS-1:0]     an_log;
  logic [6:0]            seg_log;
  logic                  dp_log;

  // Blanking chain runs from the top digit down; digit 0 always shows.
  always_comb begin
    blank = '0;
    chain = sh_blz;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (chain && sh_data[4*i +: 4] == 4'h0 && !sh_dp[i])
        blank[i] = 1'b1;
      else
        chain = 1'b0;
    end
  end

  assign nib   = sh_data[{digit_idx, 2'b00} +: 4];
  assign phase = div_cnt[CW-1 -: PWM_BITS];

  always_comb begin
    unique case (nib)
      4'h0: dec = 7'h7E;
      4'h1: dec = 7'h30;
      4'h2: dec = 7'h6D;
      4'h3: dec = 7'h79;
      4'h4: dec = 7'h33;
      4'h5: dec = 7'h5B;
      4'h6: dec = 7'h5F;
      4'h7: dec = 7'h70;
      4'h8: dec = 7'h7F;
      4'h9: dec = 7'h7B;
      4'hA: dec = 7'h77;
      4'hB: dec = 7'h1F;
      4'hC: dec = 7'h4E;
      4'hD: dec = 7'h3D;
      4'hE: dec = 7'h4F;
      4'hF: dec = 7'h47;
    endcase
  end

  always_comb begin
    lit = (div_cnt >= CW'(GUARD))
       && sh_en[digit_idx]
       && !blank[digit_idx]
       && (phase <= sh_bri);
    an_log  = lit ? (DIGITS'(1) << digit_idx) : '0;
    seg_log = blank[digit_idx] ? 7'h00 : dec;
    dp_log  = !blank[digit_idx] && sh_dp[digit_idx];
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      div_cnt    <= '0;
      digit_idx  <= '0;
      frame_tick <= 1'b0;
      sh_data    <= '0;
      sh_dp      <= '0;
      sh_en      <= '0;
      sh_blz     <= 1'b0;
      sh_bri     <= '0;
      anodes     <= {DIGITS{AL_AN}};
      segments   <= {7{AL_SEG}};
      seg_dp     <= AL_SEG;
    end else begin
      frame_tick <= 1'b0;
      div_cnt    <= div_cnt + 1'b1;
      if (div_cnt == CW'(SCAN_DIV - 1)) begin
        if (digit_idx == IW'(DIGITS - 1)) begin
          digit_idx  <= '0;
          frame_tick <= 1'b1;
          sh_data    <= data;
          sh_dp      <= dp;
          sh_en      <= digit_en;
          sh_blz     <= blank_lz;
          sh_bri     <= brightness;
        end else begin
          digit_idx <= digit_idx + 1'b1;
        end
      end
      anodes   <= an_log ^ {DIGITS{AL_AN}};
      segments <= seg_log ^ {7{AL_SEG}};
      seg_dp   <= dp_log ^ AL_SEG;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: directed and random inputs checked every
// cycle against a frame-level model of the scanner.
module tb_seg7_scan_ctrl;

  localparam int ND = 4;
  localparam int SD = 16;
  localparam int PB = 2;
  localparam int G  = 2;
  localparam int F  = ND * SD;

  logic            CLK = 1'b0;
  logic            RST_N = 1'b0;
  logic [15:0]     data = '0;
  logic [3:0]      dp = '0;
  logic [3:0]      digit_en = '0;
  logic            blank_lz = 1'b0;
  logic [1:0]      brightness = '0;
  logic [3:0]      anodes;
  logic [6:0]      segments;
  logic            seg_dp;
  logic [1:0]      digit_idx;
  logic            frame_tick;

  seg7_scan_ctrl #(
    .DIGITS(ND), .SCAN_DIV(SD), .PWM_BITS(PB), .GUARD(G),
    .ACTIVE_LOW_AN(1), .ACTIVE_LOW_SEG(1)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .data(data), .dp(dp),
    .digit_en(digit_en), .blank_lz(blank_lz),
    .brightness(brightness), .anodes(anodes),
    .segments(segments), .seg_dp(seg_dp),
    .digit_idx(digit_idx), .frame_tick(frame_tick)
  );

  always #5 CLK = ~CLK;

  logic [6:0] dec_tab [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
  };

  int n_chk = 0;
  int n_pass = 0;
  int k = 0;
  bit rnd_mode = 0;

  logic [15:0] m_data;
  logic [3:0]  m_dp, m_en;
  logic        m_blz;
  logic [1:0]  m_bri;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cycle=%0d got=%h exp=%h", tag, k, got, exp);
  endtask

  // Expected {anodes, segments, seg_dp} for counter state t.
  function automatic logic [11:0] model(int t);
    int div, idx, nb, msd, ph;
    bit bl, lit;
    logic [3:0] an;
    logic [6:0] sg;
    logic dpo;
    div = t % SD;
    idx = (t / SD) % ND;
    msd = 0;
    for (int j = 0; j < ND; j++)
      if (((m_data >> (4*j)) & 16'hF) != 0 || m_dp[j]) msd = j;
    bl  = m_blz && (idx > msd);
    nb  = int'((m_data >> (4*idx)) & 16'hF);
    ph  = div / (SD >> PB);
    lit = (div >= G) && m_en[idx] && !bl && (ph <= int'(m_bri));
    an  = lit ? ~(4'b0001 << idx) : 4'hF;
    sg  = bl ? 7'h7F : ~dec_tab[nb];
    dpo = bl ? 1'b1 : ~m_dp[idx];
    return {an, sg, dpo};
  endfunction

  task automatic randomize_inputs();
    logic [15:0] d;
    d = 16'($urandom);
    for (int j = 0; j < ND; j++)
      if ($urandom_range(0, 1) == 0) d[4*j +: 4] = 4'h0;
    data       = d;
    dp         = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
    digit_en   = 4'($urandom);
    blank_lz   = 1'($urandom);
    brightness = 2'($urandom);
  endtask

  task automatic run_cycles(int n);
    logic [11:0] e;
    for (int c = 0; c < n; c++) begin
      @(posedge CLK);
      e = model(k);
      k++;
      if (k % F == 0) begin
        m_data = data; m_dp = dp; m_en = digit_en;
        m_blz = blank_lz; m_bri = brightness;
      end
      #1;
      chk("anodes", 32'(anodes), 32'(e[11:8]));
      chk("segments", 32'(segments), 32'(e[7:1]));
      chk("seg_dp", 32'(seg_dp), 32'(e[0]));
      chk("digit_idx", 32'(digit_idx), 32'((k / SD) % ND));
      chk("frame_tick", 32'(frame_tick), 32'(k % F == 0));
      if (rnd_mode && $urandom_range(0, 29) == 0) randomize_inputs();
    end
  endtask

  task automatic check_reset_outputs(string tag);
    chk({tag, "_an"}, 32'(anodes), 32'h0000000F);
    chk({tag, "_seg"}, 32'(segments), 32'h0000007F);
    chk({tag, "_dp"}, 32'(seg_dp), 32'h00000001);
    chk({tag, "_idx"}, 32'(digit_idx), 32'h00000000);
    chk({tag, "_tick"}, 32'(frame_tick), 32'h00000000);
  endtask

  task automatic model_reset();
    k = 0;
    m_data = '0; m_dp = '0; m_en = '0; m_blz = 0; m_bri = '0;
  endtask

  task automatic set_in(logic [15:0] d, logic [3:0] p, logic [3:0] en,
                        logic blz, logic [1:0] b);
    data = d; dp = p; digit_en = en; blank_lz = blz; brightness = b;
  endtask

  initial begin
    model_reset();
    set_in(16'h1234, 4'h0, 4'hF, 1'b0, 2'd3);
    #23;
    check_reset_outputs("rst");
    @(negedge CLK);
    RST_N = 1'b1;

    run_cycles(3 * F);
    set_in(16'h1234, 4'h0, 4'hF, 1'b0, 2'd0);
    run_cycles(2 * F);
    set_in(16'h0070, 4'h0, 4'hF, 1'b1, 2'd3);
    run_cycles(2 * F);
    set_in(16'h0000, 4'h0, 4'hF, 1'b1, 2'd3);
    run_cycles(2 * F);
    set_in(16'h0000, 4'b0100, 4'hF, 1'b1, 2'd3);
    run_cycles(2 * F);

    set_in(16'h1234, 4'h0, 4'hF, 1'b0, 2'd3);
    run_cycles(F);
    while (k % F != SD + SD / 2) run_cycles(1);
    data = 16'hABCD;
    run_cycles(2 * F);

    set_in(16'h1234, 4'h0, 4'b1010, 1'b0, 2'd3);
    run_cycles(2 * F);

    rnd_mode = 1;
    randomize_inputs();
    run_cycles(16 * F);
    rnd_mode = 0;

    while (k % SD != 7) run_cycles(1);
    #2;
    RST_N = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    model_reset();
    set_in(16'h5678, 4'b0011, 4'hF, 1'b0, 2'd2);
    run_cycles(3 * F);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
